// File: rtl/lcd_pkg.sv
// Shared types, constants and address helpers for the HD44780-style bus monitor.
// Pure declarations: no latency, no flow control.
// Used by lcd_bus_monitor for command decode and DDRAM address stepping.
package lcd_pkg;

    typedef enum logic [3:0] {
        CMD_NONE,
        CLEAR,
        HOME,
        ENTRY,
        DISP,
        SHIFT,
        FUNC,
        CGRAM,
        DDRAM
    } cmd_class_t;

    typedef struct packed {
        logic       e;
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } lcd_bus_t;

    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam int         LINE_LEN   = 40;
    localparam int         VISIBLE    = 16;
    localparam logic [7:0] SPACE      = 8'h20;

    localparam logic [6:0] LINE1_LAST = LINE1_BASE + 7'(LINE_LEN - 1);
    localparam logic [6:0] LINE2_LAST = LINE2_BASE + 7'(LINE_LEN - 1);

    function automatic cmd_class_t cmd_decode(input logic [7:0] b);
        cmd_class_t c;
        c = CMD_NONE;
        if (b[7])      c = DDRAM;
        else if (b[6]) c = CGRAM;
        else if (b[5]) c = FUNC;
        else if (b[4]) c = SHIFT;
        else if (b[3]) c = DISP;
        else if (b[2]) c = ENTRY;
        else if (b[1]) c = HOME;
        else if (b[0]) c = CLEAR;
        return c;
    endfunction

    // Only 0x00-0x27 and 0x40-0x67 exist in a 2-line controller.
    function automatic logic addr_invalid(input logic [6:0] a);
        return (a > LINE1_LAST && a < LINE2_BASE) || (a > LINE2_LAST);
    endfunction

    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if (a == LINE1_LAST)      n = LINE2_BASE;
            else if (a == LINE2_LAST) n = LINE1_BASE;
            else                      n = a + 7'd1;
        end else begin
            if (a == LINE1_BASE)      n = LINE2_LAST;
            else if (a == LINE2_BASE) n = LINE1_LAST;
            else                      n = a - 7'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/lcd_evt_fifo.sv
// Generic synchronous FIFO for decoded bus events.
// Latency: a push is visible at the head (empty deasserts) one cycle later, no bypass.
// Backpressure: push while full is refused unless a pop happens in the same cycle.
module lcd_evt_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 9,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 bus tap: decodes E-fall strobes into a 2x16 shadow, mode state and an event stream.
// Latency: pin E fall to state update SYNC_STAGES+1 cycles; evt_valid one cycle later.
// Backpressure: evt_ready stalls the event FIFO; pushes into a full FIFO are dropped and flagged.
module lcd_bus_monitor
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rw,
    input  logic       lcd_rs,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       evt_is_data,
    output logic [7:0] evt_byte,
    output logic [6:0] ddram_addr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_mode,
    output logic       shift_mode,
    output logic       func_ok,
    output logic       evt_overflow,
    output logic       read_seen,
    output logic       addr_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    lcd_bus_t   sync_q [SYNC_STAGES];
    lcd_bus_t   prev_q;
    logic       strobe;
    logic [7:0] shadow [32];
    logic       cgram_mode;

    logic       evt_push;
    logic [8:0] evt_push_dat;
    logic [8:0] evt_head;
    logic       evt_full;
    logic       evt_empty;
    logic       evt_pop;
    logic [CW-1:0] evt_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= '{e: lcd_e, rs: lcd_rs, rw: lcd_rw, data: lcd_data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // prev_q is the last sample with E high, so it carries the strobed rs/rw/data.
    assign strobe = prev_q.e && !sync_q[SYNC_STAGES-1].e;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) shadow[i] <= SPACE;
            ddram_addr <= LINE1_BASE;
            disp_on    <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            inc_mode   <= 1'b1;
            shift_mode <= 1'b0;
            func_ok    <= 1'b0;
            cgram_mode <= 1'b0;
            read_seen  <= 1'b0;
            addr_err   <= 1'b0;
        end else if (strobe) begin
            if (prev_q.rw) begin
                read_seen <= 1'b1;
            end else if (!prev_q.rs) begin
                case (cmd_decode(prev_q.data))
                    CLEAR: begin
                        for (int i = 0; i < 32; i++) shadow[i] <= SPACE;
                        ddram_addr <= LINE1_BASE;
                        inc_mode   <= 1'b1;
                        cgram_mode <= 1'b0;
                    end
                    HOME: begin
                        ddram_addr <= LINE1_BASE;
                        cgram_mode <= 1'b0;
                    end
                    ENTRY: begin
                        inc_mode   <= prev_q.data[1];
                        shift_mode <= prev_q.data[0];
                    end
                    DISP: begin
                        disp_on   <= prev_q.data[2];
                        cursor_on <= prev_q.data[1];
                        blink_on  <= prev_q.data[0];
                    end
                    SHIFT: begin
                        if (!prev_q.data[3]) ddram_addr <= addr_step(ddram_addr, prev_q.data[2]);
                    end
                    FUNC:  func_ok    <= prev_q.data[4] & prev_q.data[3];
                    CGRAM: cgram_mode <= 1'b1;
                    DDRAM: begin
                        cgram_mode <= 1'b0;
                        if (addr_invalid(prev_q.data[6:0])) begin
                            ddram_addr <= LINE1_BASE;
                            addr_err   <= 1'b1;
                        end else begin
                            ddram_addr <= prev_q.data[6:0];
                        end
                    end
                    default: ;
                endcase
            end else if (!cgram_mode) begin
                // Only the first VISIBLE columns of each line are mirrored.
                if (ddram_addr[6:4] == LINE1_BASE[6:4])
                    shadow[{1'b0, ddram_addr[3:0]}] <= prev_q.data;
                else if (ddram_addr[6:4] == LINE2_BASE[6:4])
                    shadow[{1'b1, ddram_addr[3:0]}] <= prev_q.data;
                ddram_addr <= addr_step(ddram_addr, inc_mode);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_char <= SPACE;
        else     rd_char <= shadow[rd_addr];
    end

    // Event push is registered so evt_valid trails the state update by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_push     <= 1'b0;
            evt_push_dat <= '0;
            evt_overflow <= 1'b0;
        end else begin
            evt_push     <= strobe && !prev_q.rw;
            evt_push_dat <= {prev_q.rs, prev_q.data};
            if (evt_push && evt_full && !evt_pop) evt_overflow <= 1'b1;
        end
    end

    assign evt_valid   = (evt_count != '0);
    assign evt_pop     = evt_ready && !evt_empty;
    assign evt_is_data = evt_head[8];
    assign evt_byte    = evt_head[7:0];

    lcd_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (9)
    ) u_evt_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (evt_push),
        .push_dat (evt_push_dat),
        .full     (evt_full),
        .pop      (evt_pop),
        .pop_dat  (evt_head),
        .empty    (evt_empty),
        .count    (evt_count)
    );

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor: drives the LCD bus, checks shadow, mode state and events.
module tb_lcd_bus_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_e = 1'b0, lcd_rw = 1'b0, lcd_rs = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic       evt_valid, evt_ready = 1'b1, evt_is_data;
    logic [7:0] evt_byte;
    logic [6:0] ddram_addr;
    logic       disp_on, cursor_on, blink_on, inc_mode, shift_mode, func_ok;
    logic       evt_overflow, read_seen, addr_err;

    int n_vec  = 0;
    int n_fail = 0;

    logic       exp_is_data [4];
    logic [7:0] exp_byte    [4];
    logic [7:0] hello       [5];

    lcd_bus_monitor #(.SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .lcd_e        (lcd_e),
        .lcd_rw       (lcd_rw),
        .lcd_rs       (lcd_rs),
        .lcd_data     (lcd_data),
        .rd_addr      (rd_addr),
        .rd_char      (rd_char),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_is_data  (evt_is_data),
        .evt_byte     (evt_byte),
        .ddram_addr   (ddram_addr),
        .disp_on      (disp_on),
        .cursor_on    (cursor_on),
        .blink_on     (blink_on),
        .inc_mode     (inc_mode),
        .shift_mode   (shift_mode),
        .func_ok      (func_ok),
        .evt_overflow (evt_overflow),
        .read_seen    (read_seen),
        .addr_err     (addr_err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise E with the given controls for 4 cycles, then drop it; returns at the falling edge.
    task automatic lcd_hold(input logic rs, input logic rw, input logic [7:0] b);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = b; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
    endtask

    task automatic lcd_write(input logic rs, input logic [7:0] b);
        lcd_hold(rs, 1'b0, b);
        repeat (6) @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = 5'(a);
        @(negedge clk);
        chk(tag, {24'd0, rd_char}, {24'd0, exp});
    endtask

    initial begin
        hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;
        exp_is_data[0] = 1'b1; exp_byte[0] = 8'h61;
        exp_is_data[1] = 1'b0; exp_byte[1] = 8'h0F;
        exp_is_data[2] = 1'b1; exp_byte[2] = 8'h62;
        exp_is_data[3] = 1'b1; exp_byte[3] = 8'h63;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_addr", 32'(ddram_addr), 32'h00);
        chk("rst_inc", 32'(inc_mode), 32'd1);
        chk("rst_disp", 32'(disp_on), 32'd0);
        chk("rst_func", 32'(func_ok), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_flags", {29'd0, evt_overflow, read_seen, addr_err}, 32'd0);
        chk("rst_rdchar", 32'(rd_char), 32'h20);

        // Stray byte then init sequence; the clear must wipe it
        lcd_write(1'b1, 8'h41);
        chk("pre_addr", 32'(ddram_addr), 32'h01);
        lcd_write(1'b0, 8'h38);
        lcd_write(1'b0, 8'h0C);
        lcd_write(1'b0, 8'h06);
        lcd_write(1'b0, 8'h01);
        chk("init_func", 32'(func_ok), 32'd1);
        chk("init_disp", 32'(disp_on), 32'd1);
        chk("init_cursor", 32'(cursor_on), 32'd0);
        chk("init_blink", 32'(blink_on), 32'd0);
        chk("init_inc", 32'(inc_mode), 32'd1);
        chk("init_addr", 32'(ddram_addr), 32'h00);
        for (int i = 0; i < 32; i++) rd_chk($sformatf("init_sh%0d", i), i, 8'h20);

        // HELLO on line 1, AB on line 2
        lcd_write(1'b0, 8'h80);
        for (int i = 0; i < 5; i++) lcd_write(1'b1, hello[i]);
        lcd_write(1'b0, 8'hC0);
        lcd_write(1'b1, 8'h41);
        lcd_write(1'b1, 8'h42);
        chk("ab_addr", 32'(ddram_addr), 32'h42);
        for (int i = 0; i < 5; i++) rd_chk($sformatf("hello%0d", i), i, hello[i]);
        rd_chk("sh5", 5, 8'h20);
        rd_chk("sh16", 16, 8'h41);
        rd_chk("sh18", 18, 8'h20);
        // Registered read: one cycle after rd_addr changes
        @(negedge clk);
        rd_addr = 5'd17;
        @(negedge clk);
        chk("rd_lat", 32'(rd_char), 32'h42);

        // Invisible column, wrap 0x27->0x40 on increment
        lcd_write(1'b0, 8'hA7);
        chk("a7_addr", 32'(ddram_addr), 32'h27);
        lcd_write(1'b1, 8'h58);
        chk("wrap_inc", 32'(ddram_addr), 32'h40);
        rd_chk("nostore16", 16, 8'h41);
        rd_chk("nostore4", 4, 8'h4F);
        // Decrement mode, wrap 0x40->0x27
        lcd_write(1'b0, 8'h04);
        chk("entry_inc0", 32'(inc_mode), 32'd0);
        lcd_write(1'b0, 8'hC0);
        lcd_write(1'b1, 8'h59);
        chk("wrap_dec", 32'(ddram_addr), 32'h27);
        rd_chk("dec_store", 16, 8'h59);
        // Cursor shift commands
        lcd_write(1'b0, 8'h14);
        chk("shift_r", 32'(ddram_addr), 32'h40);
        lcd_write(1'b0, 8'h10);
        chk("shift_l", 32'(ddram_addr), 32'h27);
        lcd_write(1'b0, 8'h18);
        chk("disp_shift", 32'(ddram_addr), 32'h27);
        lcd_write(1'b0, 8'h0F);
        chk("cur_blink", {30'd0, cursor_on, blink_on}, 32'd3);
        lcd_write(1'b0, 8'h07);
        chk("entry_shift", {30'd0, inc_mode, shift_mode}, 32'd3);

        // Invalid DDRAM address
        chk("err_pre", 32'(addr_err), 32'd0);
        lcd_write(1'b0, 8'hB0);
        chk("err_addr", 32'(ddram_addr), 32'h00);
        chk("err_flag", 32'(addr_err), 32'd1);

        // CGRAM mode discards data
        lcd_write(1'b0, 8'h40);
        lcd_write(1'b1, 8'h55);
        chk("cg_addr", 32'(ddram_addr), 32'h00);
        rd_chk("cg_nostore", 0, 8'h48);
        lcd_write(1'b0, 8'h80);

        // Read strobe: flagged, not queued
        lcd_hold(1'b0, 1'b1, 8'h00);
        repeat (6) @(negedge clk);
        chk("read_seen", 32'(read_seen), 32'd1);
        chk("read_novalid", 32'(evt_valid), 32'd0);
        chk("read_addr", 32'(ddram_addr), 32'h00);

        // Overflow with evt_ready low; first write checks exact latency
        evt_ready = 1'b0;
        lcd_hold(1'b1, 1'b0, 8'h61);
        repeat (3) @(negedge clk);
        chk("lat_addr", 32'(ddram_addr), 32'h01);
        chk("lat_novalid", 32'(evt_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(evt_valid), 32'd1);
        repeat (2) @(negedge clk);
        lcd_write(1'b0, 8'h0F);
        lcd_write(1'b1, 8'h62);
        lcd_write(1'b1, 8'h63);
        chk("ovf_pre", 32'(evt_overflow), 32'd0);
        lcd_write(1'b1, 8'h64);
        lcd_write(1'b1, 8'h65);
        chk("ovf_flag", 32'(evt_overflow), 32'd1);
        chk("ovf_addr", 32'(ddram_addr), 32'h05);
        rd_chk("ovf_store", 4, 8'h65);
        chk("hold_byte0", 32'(evt_byte), 32'h61);
        repeat (3) @(negedge clk);
        chk("hold_byte1", 32'(evt_byte), 32'h61);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pop%0d_valid", i), 32'(evt_valid), 32'd1);
            chk($sformatf("pop%0d_isdata", i), 32'(evt_is_data), 32'(exp_is_data[i]));
            chk($sformatf("pop%0d_byte", i), 32'(evt_byte), 32'(exp_byte[i]));
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("drained", 32'(evt_valid), 32'd0);

        // Reset while E is high, E drops right at release: strobe must be ignored
        @(negedge clk);
        lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h77; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lcd_e = 1'b0;
        repeat (8) @(negedge clk);
        chk("rsts_valid", 32'(evt_valid), 32'd0);
        chk("rsts_addr", 32'(ddram_addr), 32'h00);
        chk("rsts_mode", {29'd0, inc_mode, disp_on, func_ok}, 32'h4);
        chk("rsts_flags", {29'd0, evt_overflow, read_seen, addr_err}, 32'd0);
        rd_chk("rsts_sh0", 0, 8'h20);
        // Next full strobe decodes normally
        lcd_write(1'b1, 8'h77);
        chk("post_addr", 32'(ddram_addr), 32'h01);
        chk("post_valid", 32'(evt_valid), 32'd1);
        chk("post_isdata", 32'(evt_is_data), 32'd1);
        chk("post_byte", 32'(evt_byte), 32'h77);
        rd_chk("post_sh0", 0, 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
